// File: rtl/signed_stat_tracker.sv
// Signed running max/min/last tracker with a DEPTH-stage delay line and registered result mux.
// Latency: DATA_OUT/OUT_VALID/SAMPLES update one edge after inputs; no backpressure, a sample is taken every RUN edge.
module signed_stat_tracker #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         DATA_IN,
  input  logic                     ENABLE,
  input  logic                     AVERAGE,
  input  logic                     RESTART,
  input  logic                     CLEAR,
  input  logic [$clog2(DEPTH)-1:0] TAP_SEL,
  output logic [WIDTH-1:0]         DATA_OUT,
  output logic                     OUT_VALID,
  output logic [CNT_W-1:0]         SAMPLES
);

  typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] rmax;
  logic [WIDTH-1:0] rmin;
  logic [WIDTH-1:0] rlast;
  logic [WIDTH-1:0] tap [DEPTH];
  logic [WIDTH-1:0] tap_q;
  logic             seed_now;

  // floor((a+b)/2) on sign-extended operands; the extra bit absorbs the carry
  function automatic logic [WIDTH-1:0] avg(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    return sum[WIDTH:1];
  endfunction

  always_comb begin
    tap_q = tap[DEPTH-1];
    if (int'(TAP_SEL) < DEPTH) tap_q = tap[TAP_SEL];
  end

  assign seed_now = (state == SEED) || ((state == RUN) && CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rmax      <= '0;
      rmin      <= '0;
      rlast     <= '0;
      DATA_OUT  <= '0;
      OUT_VALID <= 1'b0;
      SAMPLES   <= '0;
      for (int i = 0; i < DEPTH; i++) tap[i] <= '0;
    end else begin
      case (state)
        IDLE:    state <= SEED;
        SEED:    state <= RUN;
        RUN:     state <= CLEAR ? SEED : RUN;
        default: state <= IDLE;
      endcase
      OUT_VALID <= (state == SEED) || ((state == RUN) && !CLEAR);

      if (seed_now) begin
        rmax     <= DATA_IN;
        rmin     <= DATA_IN;
        rlast    <= '0;
        DATA_OUT <= '0;
        SAMPLES  <= '0;
        for (int i = 0; i < DEPTH; i++) tap[i] <= '0;
      end else if (state == RUN) begin
        if (ENABLE) begin
          rlast <= DATA_IN;
          if (SAMPLES != {CNT_W{1'b1}}) SAMPLES <= SAMPLES + 1'b1;
        end

        if (RESTART)      DATA_OUT <= avg(rmax, rmin);
        else if (ENABLE)  DATA_OUT <= AVERAGE ? tap_q : avg(DATA_IN, tap_q);
        else              DATA_OUT <= rlast;

        // min is only tested when max did not move, which keeps rmin <= rmax
        if ($signed(DATA_IN) > $signed(rmax))      rmax <= DATA_IN;
        else if ($signed(DATA_IN) < $signed(rmin)) rmin <= DATA_IN;

        tap[0] <= DATA_IN;
        for (int i = 1; i < DEPTH; i++) tap[i] <= tap[i-1];
      end
    end
  end

endmodule

// File: tb/tb_signed_stat_tracker.sv
// Directed bench for signed_stat_tracker (WIDTH=8, DEPTH=4, CNT_W=4 so saturation is reachable).
module tb_signed_stat_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] DATA_IN;
  logic       ENABLE, AVERAGE, RESTART, CLEAR;
  logic [1:0] TAP_SEL;
  logic [7:0] DATA_OUT;
  logic       OUT_VALID;
  logic [3:0] SAMPLES;

  int checks = 0;
  int errors = 0;

  signed_stat_tracker #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .DATA_IN  (DATA_IN),
    .ENABLE   (ENABLE),
    .AVERAGE  (AVERAGE),
    .RESTART  (RESTART),
    .CLEAR    (CLEAR),
    .TAP_SEL  (TAP_SEL),
    .DATA_OUT (DATA_OUT),
    .OUT_VALID(OUT_VALID),
    .SAMPLES  (SAMPLES)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // apply one set of inputs, take one edge, land 1 time unit after it
  task automatic cyc(input logic [7:0] d, input logic en, input logic av,
                     input logic rs, input logic cl, input logic [1:0] ts);
    DATA_IN = d; ENABLE = en; AVERAGE = av; RESTART = rs; CLEAR = cl; TAP_SEL = ts;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    DATA_IN = '0; ENABLE = 0; AVERAGE = 0; RESTART = 0; CLEAR = 0; TAP_SEL = '0;
    #2;
    chk("rst_out",   DATA_OUT,  0);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_samp",  SAMPLES,   0);
    #10 rst_n = 1'b1;

    // IDLE -> SEED, then SEED edge captures 0x05
    cyc(8'h05, 0, 0, 0, 0, 0);
    chk("idle_valid", OUT_VALID, 0);
    cyc(8'h05, 0, 0, 0, 0, 0);
    chk("seed_valid", OUT_VALID, 1);
    chk("seed_out",   DATA_OUT,  0);
    cyc(8'h05, 0, 0, 1, 0, 0);
    chk("seed_extremes", DATA_OUT, 8'h05);
    chk("seed_samp",     SAMPLES,  0);

    // signed extremes
    cyc(8'hF0, 1, 1, 0, 0, 0);  chk("ext_tap0_a", DATA_OUT, 8'h05);
    cyc(8'h7F, 1, 1, 0, 0, 0);  chk("ext_tap0_b", DATA_OUT, 8'hF0);
    cyc(8'h10, 1, 1, 0, 0, 0);  chk("ext_tap0_c", DATA_OUT, 8'h7F);
    cyc(8'h10, 1, 1, 1, 0, 0);
    chk("ext_restart", DATA_OUT, 8'h37);
    chk("ext_samp",    SAMPLES,  4);

    // CLEAR mid-RUN re-seeds from 0x40
    cyc(8'h40, 0, 0, 0, 1, 0);
    chk("clr_valid", OUT_VALID, 0);
    chk("clr_out",   DATA_OUT,  0);
    chk("clr_samp",  SAMPLES,   0);
    cyc(8'h40, 0, 0, 0, 0, 0);
    chk("clr_valid_back", OUT_VALID, 1);
    cyc(8'h40, 0, 0, 1, 0, 0);
    chk("clr_extremes", DATA_OUT, 8'h40);
    cyc(8'h41, 1, 1, 0, 0, 1);
    chk("clr_taps_zero", DATA_OUT, 8'h00);
    chk("clr_samp_one",  SAMPLES,  1);

    // re-seed at 0, then ramp through tap 3
    cyc(8'h00, 0, 0, 0, 1, 0);
    cyc(8'h00, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(i[7:0], 1, 1, 0, 0, 3);
      chk("ramp", DATA_OUT, (i <= 4) ? 0 : (i - 4));
    end
    chk("ramp_samp", SAMPLES, 8);
    cyc(8'h09, 1, 1, 1, 0, 0);
    chk("ramp_restart", DATA_OUT, 8'h04);

    // averaging with the input, rounding toward minus infinity
    cyc(8'h00, 0, 0, 0, 1, 0);
    cyc(8'h00, 0, 0, 0, 0, 0);
    cyc(8'hFF, 1, 0, 0, 0, 3);  chk("avg_ff_00", DATA_OUT, 8'hFF);
    cyc(8'hFD, 1, 0, 0, 0, 3);  chk("avg_fd_00", DATA_OUT, 8'hFE);
    cyc(8'h7F, 1, 0, 0, 0, 3);  chk("avg_7f_00", DATA_OUT, 8'h3F);
    cyc(8'h7F, 1, 0, 0, 0, 0);  chk("avg_7f_7f", DATA_OUT, 8'h7F);

    // ENABLE low holds last sample and counter, taps keep shifting
    cyc(8'h22, 1, 1, 0, 0, 0);
    chk("hold_pre",  DATA_OUT, 8'h7F);
    chk("hold_samp", SAMPLES,  5);
    cyc(8'h11, 0, 1, 0, 0, 0);  chk("hold_a", DATA_OUT, 8'h22);
    cyc(8'h12, 0, 1, 0, 0, 0);
    chk("hold_b",      DATA_OUT, 8'h22);
    chk("hold_frozen", SAMPLES,  5);
    cyc(8'h13, 1, 1, 0, 0, 2);  chk("hold_shift", DATA_OUT, 8'h22);
    cyc(8'h14, 0, 1, 1, 0, 0);  chk("hold_restart", DATA_OUT, 8'h3E);

    // counter saturates at 15
    for (int i = 0; i < 12; i++) cyc(8'h55, 1, 1, 0, 0, 0);
    chk("sat_samp", SAMPLES,  4'hF);
    chk("sat_out",  DATA_OUT, 8'h55);

    // asynchronous reset mid-RUN
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out",   DATA_OUT,  0);
    chk("arst_valid", OUT_VALID, 0);
    chk("arst_samp",  SAMPLES,   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
